// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Request/result bundle for the bit-serial subtractor.
//               master : start, a, b, bin out; busy, done, diff, bout in
//               slave  : the mirror image, used by the subtractor itself
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial diff = a - b - bin, LSB first, one bit per clock
//               through a single full-subtractor cell with a borrow flop.
//               Ports : clk  - rising-edge clock
//                       rst  - synchronous active-high reset
//                       bus  - slave side of serial_subtractor_if
//                              (start/a/b/bin in, busy/done/diff/bout out)
//               Result appears WIDTH edges after the accepting edge, with a
//               one-cycle done pulse; diff/bout hold until the next result.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full-subtractor bit cell on the current LSBs and the running borrow.
  logic             cell_ai, cell_bi, cell_ci;
  logic             cell_diff, cell_borrow;
  logic [WIDTH-1:0] sr_shift;

  assign cell_ai     = sa_q[0];
  assign cell_bi     = sb_q[0];
  assign cell_ci     = borrow_q;
  assign cell_diff   = cell_ai ^ cell_bi ^ cell_ci;
  assign cell_borrow = (~cell_ai & cell_bi) | (~(cell_ai ^ cell_bi) & cell_ci);

  // Result register fills from the MSB end so the last bit lands on top.
  generate
    if (WIDTH > 1) begin : g_sr_wide
      assign sr_shift = {cell_diff, sr_q[WIDTH-1:1]};
    end else begin : g_sr_single
      assign sr_shift = cell_diff;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sr_d     = sr_shift;
        borrow_d = cell_borrow;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the fully assembled word together with the final borrow.
          diff_d  = sr_shift;
          bout_d  = cell_borrow;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor. An 8-bit instance takes
//               directed vectors; a 4-bit instance takes an all-operand sweep
//               with back-to-back starts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst4;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int   checks   = 0;
  int   failures = 0;
  logic mon4_en  = 1'b0;
  logic [3:0] held4 = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (if8.done) begin
      check("busy_with_done8", {31'd0, if8.busy}, 32'd0);
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("diff8", {24'd0, if8.diff}, {24'd0, e.diff});
        check("bout8", {31'd0, if8.bout}, {31'd0, e.bout});
      end
    end
  end

  always @(negedge clk) begin
    if (mon4_en && !rst4) begin
      if (if4.done) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("diff4", {28'd0, if4.diff}, {28'd0, e.diff[3:0]});
          check("bout4", {31'd0, if4.bout}, {31'd0, e.bout});
        end
        held4 = if4.diff;
      end else begin
        check("diff4_hold", {28'd0, if4.diff}, {28'd0, held4});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic wait_idle8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((if8.busy || if8.done) && n < 100);
    if (n >= 100) check("timeout_idle8", 32'd1, 32'd0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((if4.busy || if4.done) && n < 100);
    if (n >= 100) check("timeout_idle4", 32'd1, 32'd0);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() > 0) check("timeout_drain8", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // Issue one 8-bit operation; returns just after the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
    exp_t e;
    wait_idle8();
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.bin   = bin;
    e.diff = ed;
    e.bout = eb;
    q8.push_back(e);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    exp_t e;

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    rst8 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, if8.busy}, 32'd0);
    check("rst_done",  {31'd0, if8.done}, 32'd0);
    check("rst_diff",  {24'd0, if8.diff}, 32'd0);
    check("rst_bout",  {31'd0, if8.bout}, 32'd0);
    check("rst_diff4", {28'd0, if4.diff}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    rst4 = 1'b0;

    // 0x5A - 0x23: busy for 8 edges, done after the 8th edge.
    op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    check("busy_after_accept", {31'd0, if8.busy}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_busy_%0d", i), {31'd0, if8.busy}, {31'd0, (i < 8)});
      check($sformatf("lat_done_%0d", i), {31'd0, if8.done}, {31'd0, (i == 8)});
    end
    drain8();

    // Borrow corner cases.
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    op8(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1);
    op8(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0);
    drain8();

    // start held high and operands changed during SHIFT.
    wait_idle8();
    if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h01; if8.bin = 1'b0;
    e.diff = 8'h7F; e.bout = 1'b0;
    q8.push_back(e);
    @(negedge clk);
    if8.a = 8'h00; if8.b = 8'hFF;
    begin
      int n = 0;
      while (!if8.done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("timeout_hold_done", 32'd1, 32'd0);
    end
    @(negedge clk);
    check("hold_idle_busy", {31'd0, if8.busy}, 32'd0);
    check("hold_idle_done", {31'd0, if8.done}, 32'd0);
    // Still requesting: the next edge accepts 0x00 - 0xFF.
    e.diff = 8'h01; e.bout = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    check("hold_reaccept_busy", {31'd0, if8.busy}, 32'd1);
    if8.start = 1'b0;
    drain8();

    // Reset during the 4th SHIFT cycle aborts the operation silently.
    wait_idle8();
    if8.start = 1'b1; if8.a = 8'h33; if8.b = 8'h11; if8.bin = 1'b0;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, if8.busy}, 32'd0);
    check("abort_done", {31'd0, if8.done}, 32'd0);
    check("abort_diff", {24'd0, if8.diff}, 32'd0);
    check("abort_bout", {31'd0, if8.bout}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | if8.done;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
    drain8();

    // Reset together with start in IDLE.
    wait_idle8();
    rst8 = 1'b1;
    if8.start = 1'b1; if8.a = 8'h44; if8.b = 8'h01;
    @(posedge clk);
    #1;
    check("rst_start_busy", {31'd0, if8.busy}, 32'd0);
    check("rst_start_done", {31'd0, if8.done}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    if8.start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | if8.busy | if8.done;
    end
    check("rst_start_quiet", {31'd0, seen}, 32'd0);

    // WIDTH=4 sweep, start held high so each IDLE cycle accepts a new pair.
    mon4_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] r;
          wait_idle4();
          if4.start = 1'b1;
          if4.a     = 4'(a);
          if4.b     = 4'(b);
          if4.bin   = 1'(c);
          r = 5'(a) - 5'(b) - 5'(c);
          e.diff = {4'h0, r[3:0]};
          e.bout = r[4];
          q4.push_back(e);
        end
      end
    end
    @(negedge clk);
    if4.start = 1'b0;
    begin
      int n = 0;
      while (q4.size() > 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (q4.size() > 0) check("timeout_drain4", 32'd1, 32'd0);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
